// File: rtl/fifo_rd_stream.sv
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Drains an FWFT FIFO read port into a valid/ready stream through a
//            two-entry buffer, with optional idle gap and a delivered-word count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam logic [7:0] c_gap = 8'(GAP_CYCLES);
  localparam logic [1:0] c_occ_empty = 2'd0;
  localparam logic [1:0] c_occ_one   = 2'd1;
  localparam logic [1:0] c_occ_full  = 2'd2;

  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [7:0]            r_gap_cnt;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic                  w_rinc;
  logic                  w_valid;
  logic                  w_hs;

  // Pop only while a buffer slot is guaranteed free; never looks at out_ready.
  assign w_rinc  = rst & enable & ~rempty & (r_occ != c_occ_full);
  assign w_valid = (r_occ != c_occ_empty) & (r_gap_cnt == 8'd0);
  assign w_hs    = w_valid & out_ready;

  assign rinc      = w_rinc;
  assign out_valid = w_valid;
  assign out_data  = r_head;
  assign word_cnt  = r_word_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ      <= c_occ_empty;
      r_head     <= '0;
      r_skid     <= '0;
      r_gap_cnt  <= 8'd0;
      r_word_cnt <= '0;
    end else begin
      case (r_occ)
        c_occ_empty: begin
          if (w_rinc) begin
            r_head <= rdata;
            r_occ  <= c_occ_one;
          end
        end
        c_occ_one: begin
          if (w_rinc && w_hs) begin
            r_head <= rdata;
          end else if (w_rinc) begin
            r_skid <= rdata;
            r_occ  <= c_occ_full;
          end else if (w_hs) begin
            r_occ  <= c_occ_empty;
          end
        end
        c_occ_full: begin
          if (w_hs) begin
            r_head <= r_skid;
            r_occ  <= c_occ_one;
          end
        end
        default: r_occ <= c_occ_empty;
      endcase

      // A fresh handshake always restarts the gap, even if one is pending.
      if (w_hs) begin
        r_gap_cnt  <= c_gap;
        r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
      end else if (r_gap_cnt != 8'd0) begin
        r_gap_cnt  <= r_gap_cnt - 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// Module   : tb_fifo_rd_stream
// Brief    : Directed bench with FIFO model and in-order scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       enable;
  logic       out_ready;

  logic       rempty_a, rinc_a, valid_a;
  logic [7:0] rdata_a, data_a;
  logic [3:0] cnt_a;

  logic       rempty_b, rinc_b, valid_b;
  logic [7:0] rdata_b, data_b;
  logic [15:0] cnt_b;

  fifo_rd_stream #(.DATA_WIDTH(8), .GAP_CYCLES(0), .CNT_WIDTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .rempty(rempty_a), .rdata(rdata_a),
    .rinc(rinc_a), .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
    .word_cnt(cnt_a)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .GAP_CYCLES(3), .CNT_WIDTH(16)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .rempty(rempty_b), .rdata(rdata_b),
    .rinc(rinc_b), .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
    .word_cnt(cnt_b)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] fq_a[$];
  logic [7:0] exp_a[$];
  logic [7:0] fq_b[$];
  logic [7:0] exp_b[$];
  int pend_a = 0, pend_b = 0, pops_a = 0, hs_a = 0, hs_b = 0, low_b = 0;
  bit seen_b = 1'b0;
  logic m_rst, m_ra, m_rb, m_ha, m_hb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    rempty_a = (fq_a.size() == 0);
    rdata_a  = rempty_a ? 8'h00 : fq_a[0];
    rempty_b = (fq_b.size() == 0);
    rdata_b  = rempty_b ? 8'h00 : fq_b[0];
  endtask

  task automatic push_a(input logic [7:0] w);
    fq_a.push_back(w);
    exp_a.push_back(w);
    refresh();
  endtask

  task automatic push_b(input logic [7:0] w);
    fq_b.push_back(w);
    exp_b.push_back(w);
    refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain_a(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_a.size() == 0) break;
      step();
    end
    check(tag, 32'(exp_a.size()), 32'd0);
    step();
  endtask

  // FIFO model: pops on rinc, and on a reset edge discards words that were popped but not delivered.
  always begin
    @(posedge clk);
    m_rst = rst;
    m_ra  = rinc_a;
    m_rb  = rinc_b;
    m_ha  = valid_a & out_ready;
    m_hb  = valid_b & out_ready;
    #1;
    if (!m_rst) begin
      for (int i = 0; i < pend_a; i++) void'(exp_a.pop_front());
      for (int i = 0; i < pend_b; i++) void'(exp_b.pop_front());
      pend_a = 0;
      pend_b = 0;
      hs_a   = 0;
      hs_b   = 0;
    end else begin
      if (m_ra) begin
        void'(fq_a.pop_front());
        pops_a++;
      end
      if (m_rb) void'(fq_b.pop_front());
      pend_a += int'(m_ra) - int'(m_ha);
      pend_b += int'(m_rb) - int'(m_hb);
    end
    refresh();
  end

  // Output monitor: order/data scoreboard, plus idle-gap length on the gapped instance.
  always @(negedge clk) begin
    if (rst && valid_a && out_ready) begin
      if (exp_a.size() == 0) check("a_extra_word", 32'd0, 32'd1);
      else check("a_data", 32'(data_a), 32'(exp_a.pop_front()));
      hs_a++;
    end
    if (rst && valid_b && out_ready) begin
      if (exp_b.size() == 0) check("b_extra_word", 32'd0, 32'd1);
      else check("b_data", 32'(data_b), 32'(exp_b.pop_front()));
      if (seen_b) check("b_gap_low_cycles", 32'(low_b), 32'd3);
      low_b  = 0;
      seen_b = 1'b1;
      hs_b++;
    end else if (rst && !valid_b) begin
      low_b++;
    end
  end

  int p0, h0;

  initial begin
    rst       = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    refresh();
    step();
    step();

    // Reset holds everything idle even with a non-empty FIFO
    push_a(8'h11); push_a(8'h22); push_a(8'h33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rinc", 32'(rinc_a), 32'd0);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_cnt", 32'(cnt_a), 32'd0);
    end

    // Streaming at one word per cycle
    step();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stream_rinc", 32'(rinc_a), (k < 3) ? 32'd1 : 32'd0);
      check("stream_valid", 32'(valid_a), (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
    end
    step();
    check("stream_cnt", 32'(cnt_a), 32'd3);

    // Backpressure: exactly two pops, head stable
    out_ready = 1'b0;
    p0 = pops_a;
    push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
    repeat (5) step();
    check("bp_pops", 32'(pops_a - p0), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rinc", 32'(rinc_a), 32'd0);
      check("bp_valid", 32'(valid_a), 32'd1);
      check("bp_data", 32'(data_a), 32'h11);
    end
    step();
    out_ready = 1'b1;
    drain_a("bp_drain");
    check("bp_cnt", 32'(cnt_a), 32'd7);

    // Gap of 3 idle cycles between handshakes
    push_b(8'hA1); push_b(8'hA2); push_b(8'hA3);
    for (int i = 0; i < 100; i++) begin
      if (exp_b.size() == 0) break;
      step();
    end
    check("gap_drain", 32'(exp_b.size()), 32'd0);
    step();
    check("gap_cnt", 32'(cnt_b), 32'd3);
    check("gap_hs", 32'(hs_b), 32'd3);

    // enable=0 with full buffer: buffered words still delivered, no pops
    out_ready = 1'b0;
    push_a(8'h55); push_a(8'h66); push_a(8'h77); push_a(8'h88);
    repeat (4) step();
    enable    = 1'b0;
    out_ready = 1'b1;
    p0 = pops_a;
    h0 = hs_a;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("dis_rinc", 32'(rinc_a), 32'd0);
    end
    step();
    check("dis_pops", 32'(pops_a - p0), 32'd0);
    check("dis_delivered", 32'(hs_a - h0), 32'd2);
    check("dis_valid", 32'(valid_a), 32'd0);
    enable = 1'b1;
    drain_a("dis_drain");
    check("dis_cnt", 32'(cnt_a), 32'd11);

    // Reset with full buffer: buffered words lost, rest still in FIFO
    out_ready = 1'b0;
    push_a(8'hC1); push_a(8'hC2); push_a(8'hC3); push_a(8'hC4); push_a(8'hC5);
    repeat (4) step();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_rinc", 32'(rinc_a), 32'd0);
    step();
    @(negedge clk);
    check("mrst_valid", 32'(valid_a), 32'd0);
    check("mrst_cnt", 32'(cnt_a), 32'd0);
    step();
    rst       = 1'b1;
    out_ready = 1'b1;
    drain_a("mrst_drain");
    check("mrst_cnt_after", 32'(cnt_a), 32'd3);

    // Counter wrap: 17 words on a 4-bit counter
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 17; i++) push_a(8'(8'h20 + i));
    drain_a("wrap_drain");
    check("wrap_cnt", 32'(cnt_a), 32'd1);
    check("wrap_hs", 32'(hs_a), 32'd17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
